// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg -- shared types and constants for the sequential divider.
//   state_e    : FSM states (S_SIGN exists only when SEQ_DIVIDER_SIGNED_EN is defined)
//   cnt_width  : step-counter width for a given operand width
//   DBZ_QUOT   : divide-by-zero quotient pattern (all ones, sliced to WIDTH)
// Build option: SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
package seq_divider_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
`ifdef SEQ_DIVIDER_SIGNED_EN
    ,
    S_SIGN
`endif
  } state_e;

  // The counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam logic [MAX_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if -- operand/result handshake bundle for seq_divider.
//   master : operand source / result sink (drives in_valid, operands, out_ready)
//   slave  : the divider (drives in_ready, out_valid, results, div_by_zero)
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step -- one combinational restoring-division step.
//   i_rem  : partial remainder (always < i_dvsr)
//   i_quo  : dividend bits still to shift in / quotient bits produced so far
//   i_dvsr : divisor (nonzero)
//   o_rem  : next partial remainder
//   o_quo  : next quotient register, new quotient bit in bit 0
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_rs;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // {R,Q} << 1: the dividend MSB moves into the remainder's LSB.
  assign w_rs   = {i_rem, i_quo[WIDTH-1]};
  // Since R < divisor, w_rs - divisor lies in [-divisor, divisor-1], which
  // fits WIDTH+1 bits two's complement, so bit WIDTH is a true sign bit.
  assign w_diff = w_rs - {1'b0, i_dvsr};
  assign w_ge   = ~w_diff[WIDTH];

  assign o_rem  = w_ge ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/seq_divider.sv
// seq_divider -- iterative restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave (in_valid/in_ready operands,
//           out_valid/out_ready quotient, remainder, div_by_zero)
// Build option: SEQ_DIVIDER_SIGNED_EN -- two's-complement operands, magnitudes
// divided by the unsigned core, one extra SIGN cycle fixes result signs.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_dbz;
  logic [WIDTH-1:0] w_rem_step, w_quo_step;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic             w_dvs_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q, r_neg_r;

  assign w_dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
`else
  assign w_dvd_mag = bus.dividend;
  assign w_dvs_mag = bus.divisor;
`endif

  assign w_dvs_zero = (bus.divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_step),
    .o_quo  (w_quo_step)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          w_state_nxt = w_dvs_zero ? S_SIGN : S_CALC;
`else
          w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (r_cnt == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          w_state_nxt = S_SIGN;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      S_SIGN: w_state_nxt = S_DONE;
`endif
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; held untouched in DONE so results are stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_dvsr <= w_dvs_mag;
            r_cnt  <= CNT_W'(WIDTH-1);
            if (w_dvs_zero) begin
              // Raw dividend as remainder; sign fix-up is suppressed below.
              r_quo   <= DBZ_QUOT[WIDTH-1:0];
              r_rem   <= bus.dividend;
              r_dbz   <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
`endif
            end else begin
              r_quo   <= w_dvd_mag;
              r_rem   <= '0;
              r_dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
              r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              r_neg_r <= bus.dividend[WIDTH-1];
`endif
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt - CNT_W'(1);
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        // MIN/-1 needs no special case: magnitude 2^(W-1) reads back as MIN.
        S_SIGN: begin
          if (r_neg_q) r_quo <= ~r_quo + 1'b1;
          if (r_neg_r) r_rem <= ~r_rem + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- scoreboard bench for seq_divider (WIDTH=4).
// Expected results are pushed on accept and popped when out_valid is seen.
// Honours SEQ_DIVIDER_SIGNED_EN for the model and latency.
module tb_seq_divider;
  localparam int W = 4;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  res_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa, sd;
`endif
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa  = $signed(a);
      sd  = $signed(b);
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // One full transaction: drive, accept, wait result, hold under backpressure, drain.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input bit do_lat, input string tag);
    int   guard;
    int   lat;
    res_t e;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    sb.push_back(model(a, b));
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid === 1'b1) break;
    end
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    e = sb.pop_front();
    if (bus.out_valid !== 1'b1) return;
    if (do_lat) chk({tag, "_latency"}, lat, (b == '0) ? 32'(1 + EXTRA) : 32'(W + 1 + EXTRA));
    chk({tag, "_q"},   32'(bus.quotient),    32'(e.q));
    chk({tag, "_r"},   32'(bus.remainder),   32'(e.r));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_q"},     32'(bus.quotient),    32'(e.q));
      chk({tag, "_hold_r"},     32'(bus.remainder),   32'(e.r));
      chk({tag, "_hold_dbz"},   32'(bus.div_by_zero), 32'(e.dbz));
      chk({tag, "_hold_vld"},   32'(bus.out_valid),   32'd1);
      chk({tag, "_hold_irdy"},  32'(bus.in_ready),    32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drain_vld"},  32'(bus.out_valid), 32'd0);
    chk({tag, "_drain_irdy"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_irdy", 32'(bus.in_ready),    32'd1);
    chk("rst_ovld", 32'(bus.out_valid),   32'd0);
    chk("rst_q",    32'(bus.quotient),    32'd0);
    chk("rst_r",    32'(bus.remainder),   32'd0);
    chk("rst_dbz",  32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd13, 4'd3, 0, 1'b1, "d13_3");
    run_op(4'd9,  4'd0, 0, 1'b1, "d9_0");
    run_op(4'd2,  4'd7, 0, 1'b1, "d2_7");
    run_op(4'd15, 4'd1, 0, 1'b1, "d15_1");
    run_op(4'd12, 4'd5, 6, 1'b1, "d12_5_bp");

    // Reset in the middle of CALC: nothing of the aborted operation may surface.
    @(negedge clk);
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q",    32'(bus.quotient),    32'd0);
    chk("mid_rst_r",    32'(bus.remainder),   32'd0);
    chk("mid_rst_dbz",  32'(bus.div_by_zero), 32'd0);
    chk("mid_rst_ovld", 32'(bus.out_valid),   32'd0);
    chk("mid_rst_irdy", 32'(bus.in_ready),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("mid_rst_no_result", seen, 0);
    run_op(4'd14, 4'd3, 0, 1'b1, "d14_3_after_rst");

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(4'b1001, 4'd2,    0, 1'b1, "s_m7_2");
    run_op(4'b1000, 4'b1111, 0, 1'b1, "s_m8_m1");
`endif

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), int'($urandom_range(0, 2)), 1'b1, "sweep");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
